// File: rtl/div_32_iter_if.sv
// Request/response bundle for the iterative divider.
// The master issues operands and accepts results; the slave is the divider.
interface div_32_iter_if #(
   parameter int WORDLEN = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [WORDLEN:0]   dividend;
   logic [WORDLEN:0]   divisor;
   logic               out_valid;
   logic               out_ready;
   logic [WORDLEN-1:0] quotient;
   logic [WORDLEN-1:0] remainder;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder
   );
endinterface

// File: rtl/div_32_iter.sv
// Iterative radix-2 restoring divider working on sign-flagged operands.
// The sign bit selects magnitude extraction and the final sign fix-up;
// the divider core itself is unsigned.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// CALC  | one restoring step per cycle, WORDLEN cycles, MSB first
// FIX   | apply signs to quotient/remainder, register the results
// DONE  | result presented on out_valid until out_ready
module div_32_iter #(
   parameter int WORDLEN = 32
) (
   input logic          clk,
   input logic          rst_n,
   div_32_iter_if.slave bus
);

   localparam int CNT_W = $clog2(WORDLEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDLEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]   cnt_q;
   logic [WORDLEN-1:0] quo_q;
   logic [WORDLEN-1:0] rem_q;
   logic [WORDLEN-1:0] dvs_q;
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic [WORDLEN-1:0] quotient_q;
   logic [WORDLEN-1:0] remainder_q;

   logic [WORDLEN-1:0] dvd_mag;
   logic [WORDLEN-1:0] dvs_mag;
   logic               accept;
   logic               dvs_zero;
   logic [WORDLEN:0]   trial;
   logic               trial_ge;
   logic [WORDLEN:0]   trial_diff;

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;

   // Operand magnitudes and the single restoring step of the current cycle.
   always_comb begin
      dvd_mag    = bus.dividend[WORDLEN] ? (~bus.dividend[WORDLEN-1:0] + 1'b1)
                                         : bus.dividend[WORDLEN-1:0];
      dvs_mag    = bus.divisor[WORDLEN]  ? (~bus.divisor[WORDLEN-1:0] + 1'b1)
                                         : bus.divisor[WORDLEN-1:0];
      accept     = bus.in_valid && (state_q == IDLE);
      dvs_zero   = (dvs_mag == '0);
      trial      = {rem_q, quo_q[WORDLEN-1]};
      trial_ge   = (trial >= {1'b0, dvs_q});
      trial_diff = trial - {1'b0, dvs_q};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = dvs_zero ? DONE : CALC;
         CALC: if (cnt_q == '0) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, iteration datapath, step down-counter and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  quo_q     <= dvd_mag;
                  rem_q     <= '0;
                  dvs_q     <= dvs_mag;
                  neg_quo_q <= bus.dividend[WORDLEN] ^ bus.divisor[WORDLEN];
                  neg_rem_q <= bus.dividend[WORDLEN];
                  cnt_q     <= CNT_LAST;
                  if (dvs_zero) begin
                     // Divide-by-zero bypasses the core; raw dividend bits returned.
                     quotient_q  <= '1;
                     remainder_q <= bus.dividend[WORDLEN-1:0];
                  end
               end
            end
            CALC: begin
               if (trial_ge) begin
                  rem_q <= trial_diff[WORDLEN-1:0];
                  quo_q <= {quo_q[WORDLEN-2:0], 1'b1};
               end else begin
                  rem_q <= trial[WORDLEN-1:0];
                  quo_q <= {quo_q[WORDLEN-2:0], 1'b0};
               end
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
            FIX: begin
               quotient_q  <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
               remainder_q <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_32_iter.sv
// Directed bench for div_32_iter: hand-computed vectors, latency, hold and reset abort.
module tb_div_32_iter;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   div_32_iter_if #(.WORDLEN(W)) bus ();

   div_32_iter #(.WORDLEN(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for in_ready at a falling edge.
   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_ready_timeout"}, 64'(t < 100), 64'd1);
   endtask

   // Issue one request at a falling edge; returns after the accepting rising edge.
   task automatic issue(input logic [W:0] a, input logic [W:0] b, input string tag);
      wait_ready(tag);
      bus.in_valid = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
   endtask

   // Full operation: issue, measure latency, check results, optionally stall, release.
   task automatic do_op(input logic [W:0] a, input logic [W:0] b,
                        input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                        input int exp_lat, input int hold, input string tag);
      int lat;
      logic saw_ready;
      issue(a, b, tag);
      lat = 0;
      saw_ready = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.in_ready) saw_ready = 1'b1;
      end while (bus.out_valid !== 1'b1 && lat < 100);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_busy"}, 64'(saw_ready), 64'd0);
      chk({tag, "_quo"}, 64'(bus.quotient), 64'(exp_q));
      chk({tag, "_rem"}, 64'(bus.remainder), 64'(exp_r));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
         chk({tag, "_hold_ready"}, 64'(bus.in_ready), 64'd0);
         chk({tag, "_hold_quo"}, 64'(bus.quotient), 64'(exp_q));
         chk({tag, "_hold_rem"}, 64'(bus.remainder), 64'(exp_r));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
      chk({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_idle_quo"}, 64'(bus.quotient), 64'(exp_q));
   endtask

   initial begin
      int  guard;
      logic saw_valid;
      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.dividend  = 33'h0_0000_0064;
      bus.divisor   = 33'h0_0000_0007;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      // in_valid held high through reset must not start an operation
      chk("rst_state_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_quo", 64'(bus.quotient), 64'd0);
      chk("rst_rem", 64'(bus.remainder), 64'd0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(bus.in_ready), 64'd1);

      do_op(33'h0_0000_0064, 33'h0_0000_0007, 32'd14, 32'd2, 34, 0, "u100_7");
      do_op(33'h1_FFFF_FFF9, 33'h0_0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0, "sm7_2");
      do_op(33'h0_0000_0007, 33'h1_FFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0, "s7_m2");
      do_op(33'h1_FFFF_FFF9, 33'h1_FFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34, 0, "sm7_m2");
      do_op(33'h0_0000_0005, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'd5, 1, 0, "u5_0");
      do_op(33'h1_FFFF_FFFB, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0, "sm5_0");
      do_op(33'h1_8000_0000, 33'h1_FFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0, "smin_m1");
      do_op(33'h0_FFFF_FFFF, 33'h0_0000_0001, 32'hFFFF_FFFF, 32'd0, 34, 0, "umax_1");
      do_op(33'h0_0000_03E8, 33'h0_0000_0021, 32'd30, 32'd10, 34, 10, "hold1000_33");
      // accepted on the edge right after returning to IDLE
      do_op(33'h0_0000_0011, 33'h0_0000_0005, 32'd3, 32'd2, 34, 0, "b2b17_5");

      // Reset in the middle of CALC abandons the operation.
      issue(33'h0_0000_0064, 33'h0_0000_0007, "abort");
      saw_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_ready", 64'(bus.in_ready), 64'd1);
      guard = 0;
      while (guard < 40) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
         guard++;
      end
      chk("abort_no_valid", 64'(saw_valid), 64'd0);
      do_op(33'h0_0000_0009, 33'h0_0000_0003, 32'd3, 32'd0, 34, 0, "after_abort9_3");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_32_iter.md
DIV_32_ITER -- requirements
Module: div_32_iter

Interface
REQ-001 SHALL have parameter WORDLEN, default 32, giving the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: one clock; synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, divider idle and accepting.
REQ-006 SHALL have port dividend, input, WORDLEN+1, sign-flagged operand: bit WORDLEN is the sign, [WORDLEN-1:0] is the two's-complement value (zero-extended for unsigned ops, sign-extended for signed ops).
REQ-007 SHALL have port divisor, input, WORDLEN+1, same format as dividend.
REQ-008 SHALL have port out_valid, output, 1, result present.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-010 SHALL have port quotient, output, WORDLEN, two's-complement quotient.
REQ-011 SHALL have port remainder, output, WORDLEN, two's-complement remainder.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE; in_ready = (state==IDLE) only.
REQ-013 SHALL accept a request on an edge where in_valid && in_ready, capturing both operands and both sign bits; inputs are ignored in every other state.
REQ-014 SHALL form magnitudes |x| = sign ? (~x[WORDLEN-1:0] + 1) : x[WORDLEN-1:0], truncated to WORDLEN bits.
REQ-015 SHALL, from IDLE on accept with divisor magnitude nonzero, go to CALC and perform one radix-2 restoring step per cycle, MSB first, for exactly WORDLEN cycles, then go to FIX.
REQ-016 SHALL, in FIX (1 cycle), negate the quotient magnitude when dividend sign XOR divisor sign, negate the remainder magnitude when dividend sign = 1, register both outputs, and go to DONE.
REQ-017 SHALL, from IDLE on accept with divisor magnitude zero, go directly to DONE with quotient = all ones and remainder = dividend[WORDLEN-1:0], irrespective of sign bits.
REQ-018 SHALL assert out_valid only in DONE: WORDLEN+2 cycles after the accepting edge normally (34 for WORDLEN=32), 1 cycle after it for divide-by-zero.
REQ-019 SHALL hold quotient, remainder and out_valid stable in DONE while out_ready is low, for any number of cycles.
REQ-020 SHALL return to IDLE on the edge where out_valid && out_ready; in_ready is high in the following cycle, so back-to-back operations are separated by at least one idle cycle.
REQ-021 SHALL produce quotient = 2^(WORDLEN-1) pattern (0x80000000) and remainder = 0 for signed most-negative / -1, with no overflow flag.
REQ-022 SHALL treat operands with bit WORDLEN = 1 and bit WORDLEN-1 = 0 as illegal: results unspecified, but FSM timing and handshake unchanged.
REQ-023 SHALL keep quotient and remainder at their last values outside DONE; only out_valid qualifies them.

Reset
REQ-024 SHALL, on any edge with rst_n low, force state IDLE, out_valid = 0, quotient = 0, remainder = 0, iteration counter = 0; in_ready is 1 from the first cycle after reset.
REQ-025 SHALL abandon any in-flight operation (CALC, FIX or DONE) on reset without producing out_valid for it.
REQ-026 SHALL ignore in_valid during cycles with rst_n low.

Verification
REQ-027 SHALL verify: unsigned 100 / 7 -> quotient 14, remainder 2, out_valid exactly 34 cycles after accept, in_ready low throughout.
REQ-028 SHALL verify: signed -7 / 2 (dividend 0x1_FFFFFFF9, divisor 0x0_00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-029 SHALL verify: 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, out_valid 1 cycle after accept; signed -5 / 0 -> remainder 0xFFFFFFFB.
REQ-030 SHALL verify: signed 0x1_80000000 / 0x1_FFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0x0_FFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-031 SHALL verify: out_ready held low 10 cycles in DONE -> outputs stable, in_ready low; out_ready high -> IDLE next cycle, new request accepted the following edge.
REQ-032 SHALL verify: rst_n low for 1 cycle at CALC cycle 15 -> out_valid never asserted for that request, in_ready = 1 next cycle, next request 9 / 3 -> quotient 3, remainder 0 at normal latency.
